// File: rtl/fta_req_queue.sv
// Request queue between the core-side arbiter and the system bus: buffers
// whole request structs in a FIFO and replays the head after a bus retry.

package fta_bus_pkg;

    typedef struct packed {
        logic         cyc;
        logic         we;
        logic [15:0]  sel;
        logic [7:0]   tid;
        logic [31:0]  padr;
        logic [127:0] data;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         rty;
        logic         err;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;

endpackage

module fta_req_queue
    import fta_bus_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int RETRY_GAP = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  fta_cmd_request128_t     req_i,
    output fta_cmd_response128_t    resp_o,
    output fta_cmd_request128_t     req_o,
    input  fta_cmd_response128_t    resp_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [7:0]              retry_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [3:0]    GAP_ONE  = 4'd1;
    localparam logic [3:0]    GAP_LOAD = 4'(RETRY_GAP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [3:0]          gap_q, gap_d;
    logic [7:0]          retry_q, retry_d;
    fta_cmd_request128_t mem_q [DEPTH];

    logic push;
    logic pop;
    logic retry_hit;

    assign full_o      = (count_q == DEPTH_C);
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign retry_cnt_o = retry_q;

    // Acceptance looks only at the registered occupancy, never at a same-cycle pop.
    assign push      = req_i.cyc && !full_o;
    assign pop       = (state_q == ST_SEND) && !resp_i.rty;
    assign retry_hit = (state_q == ST_SEND) &&  resp_i.rty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        retry_d = retry_q;
        if (retry_hit && (retry_q != 8'hFF)) begin
            retry_d = retry_q + 8'd1;
        end
    end

    // Next-state logic; the gap counter belongs to the BACKOFF state.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (count_d != '0) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (resp_i.rty) begin
                    state_d = ST_BACKOFF;
                    gap_d   = GAP_LOAD;
                end else if (count_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BACKOFF: begin
                if (gap_q <= GAP_ONE) begin
                    state_d = ST_SEND;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            retry_q  <= retry_d;
        end
    end

    // Entry storage needs no reset: stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_i;
        end
    end

    always_comb begin
        req_o = '0;
        if (state_q == ST_SEND) begin
            req_o     = mem_q[rd_ptr_q];
            req_o.cyc = 1'b1;
        end
        resp_o     = resp_i;
        resp_o.rty = req_i.cyc && full_o;
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= DEPTH_C);
    a_send_nonempty: assert property (@(posedge clk) disable iff (!rst)
        (state_q == ST_SEND) |-> (count_q != '0));

endmodule

// File: tb/tb_fta_req_queue.sv
// Randomised and directed bench for fta_req_queue against a queue-based
// behavioural model of the request buffer and its retry back-off.

module tb_fta_req_queue;
    import fta_bus_pkg::*;

    localparam int DEPTH     = 4;
    localparam int RETRY_GAP = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    fta_cmd_request128_t    req_i;
    fta_cmd_request128_t    req_o;
    fta_cmd_response128_t   resp_i;
    fta_cmd_response128_t   resp_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   full_o;
    logic                   empty_o;
    logic [7:0]             retry_cnt_o;

    int errors = 0;
    int checks = 0;

    fta_cmd_request128_t mq[$];
    int                  hold      = 0;
    int                  m_retries = 0;
    bit                  log_en    = 1'b0;
    logic [31:0]         issued[$];

    fta_req_queue #(.DEPTH(DEPTH), .RETRY_GAP(RETRY_GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .resp_o      (resp_o),
        .req_o       (req_o),
        .resp_i      (resp_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .retry_cnt_o (retry_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The bus sees the head whenever something is queued and no back-off is pending.
    function automatic bit m_send();
        return (mq.size() > 0) && (hold == 0);
    endfunction

    task automatic drive(input bit cyc, input logic [31:0] padr, input bit rty);
        req_i.cyc   = cyc;
        req_i.we    = 1'($urandom);
        req_i.sel   = 16'($urandom);
        req_i.tid   = 8'($urandom);
        req_i.padr  = padr;
        req_i.data  = {$urandom, $urandom, $urandom, $urandom};
        resp_i.ack  = 1'($urandom);
        resp_i.rty  = rty;
        resp_i.err  = 1'($urandom);
        resp_i.tid  = 8'($urandom);
        resp_i.adr  = $urandom;
        resp_i.dat  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic settle();
        fta_cmd_request128_t  ereq;
        fta_cmd_response128_t eresp;
        @(negedge clk);
        ereq = '0;
        if (m_send()) ereq = mq[0];
        eresp     = resp_i;
        eresp.rty = req_i.cyc && (mq.size() == DEPTH);
        chk("count", 256'(count_o), 256'(mq.size()));
        chk("full", 256'(full_o), 256'(mq.size() == DEPTH));
        chk("empty", 256'(empty_o), 256'(mq.size() == 0));
        chk("retry_cnt", 256'(retry_cnt_o), 256'(m_retries));
        chk("req_o", 256'(req_o), 256'(ereq));
        chk("resp_o", 256'(resp_o), 256'(eresp));
        if (log_en && req_o.cyc && !resp_i.rty) issued.push_back(req_o.padr);
    endtask

    task automatic tick();
        bit send;
        bit push;
        bit pop;
        send = m_send();
        push = req_i.cyc && (mq.size() < DEPTH);
        pop  = 1'b0;
        @(posedge clk);
        if (send) begin
            if (resp_i.rty) begin
                hold = RETRY_GAP;
                if (m_retries < 255) m_retries++;
            end else begin
                pop = 1'b1;
            end
        end else if (hold > 0) begin
            hold--;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(req_i);
        #1;
    endtask

    task automatic step(input bit cyc, input logic [31:0] padr, input bit rty);
        drive(cyc, padr, rty);
        settle();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        mq.delete();
        hold      = 0;
        m_retries = 0;
        chk("rst_count", 256'(count_o), 256'(0));
        chk("rst_req_o", 256'(req_o), 256'(0));
        chk("rst_retry", 256'(retry_cnt_o), 256'(0));
        chk("rst_full", 256'(full_o), 256'(0));
        chk("rst_empty", 256'(empty_o), 256'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0);
        #1;
        do_reset();

        // Single request: one-cycle latency, then drained.
        drive(1'b1, 32'h1000, 1'b0);
        settle();
        tick();
        drive(1'b0, 32'h0, 1'b0);
        settle();
        chk("single_cyc", 256'(req_o.cyc), 256'(1));
        chk("single_padr", 256'(req_o.padr), 256'(32'h1000));
        chk("single_cnt1", 256'(count_o), 256'(1));
        tick();
        settle();
        chk("single_idle", 256'(req_o.cyc), 256'(0));
        chk("single_cnt0", 256'(count_o), 256'(0));
        tick();

        // Retry: cyc pattern 1,0,0,1 with the same head.
        do_reset();
        step(1'b1, 32'h2000, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        settle();
        chk("retry_c0", 256'(req_o.cyc), 256'(1));
        tick();
        drive(1'b0, 32'h0, 1'b0);
        settle();
        chk("retry_c1", 256'(req_o.cyc), 256'(0));
        tick();
        settle();
        chk("retry_c2", 256'(req_o.cyc), 256'(0));
        tick();
        settle();
        chk("retry_c3", 256'(req_o.cyc), 256'(1));
        chk("retry_head", 256'(req_o.padr), 256'(32'h2000));
        chk("retry_cnt1", 256'(retry_cnt_o), 256'(1));
        tick();
        repeat (3) step(1'b0, 32'h0, 1'b0);

        // Fill with the bus refusing everything: fifth push rejected.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(i), 1'b1);
        drive(1'b1, 32'h3004, 1'b1);
        settle();
        chk("fill_rty", 256'(resp_o.rty), 256'(1));
        chk("fill_full", 256'(full_o), 256'(1));
        chk("fill_cnt", 256'(count_o), 256'(4));
        tick();
        repeat (20) step(1'b0, 32'h0, 1'b0);
        chk("fill_drained", 256'(empty_o), 256'(1));

        // Concurrent push/pop at count 2, order kept across pointer wrap.
        do_reset();
        issued.delete();
        log_en = 1'b1;
        step(1'b1, 32'h100, 1'b0);
        step(1'b1, 32'h200, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h300, 1'b0);
        chk("conc_cnt", 256'(count_o), 256'(2));
        for (int k = 4; k <= 8; k++) step(1'b1, 32'(k * 32'h100), 1'b0);
        chk("conc_cnt_end", 256'(count_o), 256'(2));
        repeat (8) step(1'b0, 32'h0, 1'b0);
        log_en = 1'b0;
        chk("order_len", 256'(issued.size()), 256'(8));
        for (int i = 0; i < 8; i++)
            chk("order", 256'((i < issued.size()) ? issued[i] : 32'hFFFF_FFFF),
                256'(32'(i + 1) * 32'h100));

        // Reset while backing off with three entries queued.
        do_reset();
        step(1'b1, 32'h4000, 1'b1);
        step(1'b1, 32'h4001, 1'b1);
        step(1'b1, 32'h4002, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        settle();
        chk("midrst_cnt3", 256'(count_o), 256'(3));
        chk("midrst_backoff", 256'(req_o.cyc), 256'(0));
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            settle();
            chk("post_rst_quiet", 256'(req_o.cyc), 256'(0));
            tick();
        end

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 3) == 0);
        end

        // Retry counter saturation.
        do_reset();
        step(1'b1, 32'h5000, 1'b0);
        repeat (1000) step(1'b0, 32'h0, 1'b1);
        chk("retry_sat", 256'(retry_cnt_o), 256'(255));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
